// File: rtl/mem_port_arbiter_pkg.sv
// Shared constants and response-owner encoding for the BRAM port arbiter.
package mem_port_arbiter_pkg;

    localparam int unsigned XLEN     = 32;
    localparam int unsigned STARVE_W = 4;
    localparam int unsigned WEA_W    = 4;

    localparam logic [XLEN-1:0] DEFAULT_BASE_ADDR = 32'h4000_0000;

    typedef enum logic [1:0] {
        RESP_NONE   = 2'd0,
        RESP_IFETCH = 2'd1,
        RESP_DATA   = 2'd2
    } resp_owner_e;

endpackage

// File: rtl/mem_port_arbiter_addr_window_check.sv
// Maps a byte address onto the BRAM window: in-window flag and word address.
module addr_window_check #(
    parameter int unsigned     XLEN      = 32,
    parameter logic [XLEN-1:0] BASE_ADDR = 32'h4000_0000,
    parameter int unsigned     MEM_AW    = 12
) (
    input  logic [XLEN-1:0]   addr,
    output logic              in_window_c,
    output logic [MEM_AW-1:0] word_addr_c
);

    logic [XLEN-1:0] offset;

    // Unsigned wrap makes addresses below BASE_ADDR land far out of window.
    assign offset      = addr - BASE_ADDR;
    assign in_window_c = (offset >> (MEM_AW + 2)) == '0;
    assign word_addr_c = offset[MEM_AW+1:2];

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one 1-cycle-latency BRAM port between instruction fetch and data access.
module mem_port_arbiter #(
    parameter int unsigned     XLEN       = mem_port_arbiter_pkg::XLEN,
    parameter logic [XLEN-1:0] BASE_ADDR  = XLEN'(mem_port_arbiter_pkg::DEFAULT_BASE_ADDR),
    parameter int unsigned     MEM_AW     = 12,
    parameter int unsigned     STARVE_MAX = 3
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              i_req,
    input  logic [XLEN-1:0]   i_addr,
    output logic              i_gnt,
    output logic              i_rvalid,
    output logic [XLEN-1:0]   i_rdata,
    output logic              i_err,
    input  logic              d_req,
    input  logic [XLEN-1:0]   d_addr,
    input  logic [XLEN-1:0]   d_wdata,
    input  logic [3:0]        d_wea,
    output logic              d_gnt,
    output logic              d_rvalid,
    output logic [XLEN-1:0]   d_rdata,
    output logic              d_err,
    output logic              stall_fetch,
    output logic              mem_en,
    output logic [MEM_AW-1:0] mem_addr,
    output logic [XLEN-1:0]   mem_wdata,
    output logic [3:0]        mem_wea,
    input  logic [XLEN-1:0]   mem_rdata
);

    import mem_port_arbiter_pkg::*;

    logic [STARVE_W-1:0] starve_cnt, starve_cnt_d;
    resp_owner_e         resp_owner, resp_owner_d;
    logic                resp_err, resp_err_d;

    logic                fetch_win;
    logic                d_write;
    logic [XLEN-1:0]     win_addr;
    logic                win_in;
    logic [MEM_AW-1:0]   win_word;

    // Data has priority unless fetch has lost STARVE_MAX contested cycles in a row.
    assign fetch_win   = i_req && (!d_req || (starve_cnt == STARVE_W'(STARVE_MAX)));
    assign i_gnt       = fetch_win;
    assign d_gnt       = d_req && !fetch_win;
    assign stall_fetch = i_req && !fetch_win;
    assign d_write     = d_wea != '0;
    assign win_addr    = fetch_win ? i_addr : d_addr;

    addr_window_check #(
        .XLEN      (XLEN),
        .BASE_ADDR (BASE_ADDR),
        .MEM_AW    (MEM_AW)
    ) u_window (
        .addr        (win_addr),
        .in_window_c (win_in),
        .word_addr_c (win_word)
    );

    // Out-of-window winners are granted but never reach the BRAM.
    assign mem_en    = (i_gnt || d_gnt) && win_in;
    assign mem_addr  = win_word;
    assign mem_wdata = d_wdata;
    assign mem_wea   = (d_gnt && win_in) ? d_wea : 4'b0000;

    always_comb begin
        resp_owner_d = RESP_NONE;
        resp_err_d   = 1'b0;
        starve_cnt_d = starve_cnt;
        if (i_gnt) begin
            resp_owner_d = RESP_IFETCH;
            resp_err_d   = !win_in;
        end else if (d_gnt && !d_write) begin
            resp_owner_d = RESP_DATA;
            resp_err_d   = !win_in;
        end
        if (!i_req || i_gnt) begin
            starve_cnt_d = '0;
        end else if (d_gnt && (starve_cnt != STARVE_W'(STARVE_MAX))) begin
            starve_cnt_d = starve_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            starve_cnt <= '0;
            resp_owner <= RESP_NONE;
            resp_err   <= 1'b0;
        end else begin
            starve_cnt <= starve_cnt_d;
            resp_owner <= resp_owner_d;
            resp_err   <= resp_err_d;
        end
    end

    // Response routing: only the owner sees data; errored responses read as zero.
    assign i_rvalid = resp_owner == RESP_IFETCH;
    assign i_err    = i_rvalid && resp_err;
    assign i_rdata  = (i_rvalid && !resp_err) ? mem_rdata : '0;

    assign d_rvalid = resp_owner == RESP_DATA;
    assign d_rdata  = (d_rvalid && !resp_err) ? mem_rdata : '0;
    assign d_err    = (d_rvalid && resp_err) || (d_gnt && d_write && !win_in);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Randomized self-checking bench for mem_port_arbiter with a BRAM model and reference scoreboard.
module tb_mem_port_arbiter;

    localparam int          MEM_AW     = 12;
    localparam int          DEPTH      = 1 << MEM_AW;
    localparam int          STARVE_MAX = 3;
    localparam logic [31:0] BASE       = 32'h4000_0000;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        i_req = 1'b0, d_req = 1'b0;
    logic [31:0] i_addr = '0, d_addr = '0, d_wdata = '0, mem_rdata = '0;
    logic [3:0]  d_wea = '0;
    logic        i_gnt, i_rvalid, i_err, d_gnt, d_rvalid, d_err, stall_fetch, mem_en;
    logic [31:0] i_rdata, d_rdata, mem_wdata;
    logic [11:0] mem_addr;
    logic [3:0]  mem_wea;

    mem_port_arbiter dut (
        .clk(clk), .reset_n(reset_n),
        .i_req(i_req), .i_addr(i_addr), .i_gnt(i_gnt), .i_rvalid(i_rvalid),
        .i_rdata(i_rdata), .i_err(i_err),
        .d_req(d_req), .d_addr(d_addr), .d_wdata(d_wdata), .d_wea(d_wea),
        .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata), .d_err(d_err),
        .stall_fetch(stall_fetch), .mem_en(mem_en), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_wea(mem_wea), .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    logic [31:0] bram    [DEPTH];
    logic [31:0] ref_mem [DEPTH];

    // Reference model state: consecutive contested losses and the expected response.
    int          losses;
    int          exp_owner;     // 0 none, 1 fetch, 2 data
    logic [31:0] exp_data;
    logic        exp_err;
    int          n_checks = 0;
    int          n_fail = 0;

    function automatic logic in_win(input logic [31:0] a);
        logic [31:0] off;
        off = a - BASE;
        return off < 32'(4 * DEPTH);
    endfunction

    function automatic int widx(input logic [31:0] a);
        logic [31:0] off;
        off = a - BASE;
        return int'(off >> 2) % DEPTH;
    endfunction

    function automatic logic pred_i();
        return i_req && (!d_req || losses == STARVE_MAX);
    endfunction

    function automatic logic [31:0] rand_addr();
        int sel;
        sel = $urandom_range(0, 7);
        if (sel == 0) return BASE - 32'(4 * $urandom_range(1, 64));
        if (sel == 1) return BASE + 32'(4 * DEPTH) + 32'($urandom_range(0, 255));
        return BASE + 32'(4 * $urandom_range(0, 31)) + 32'($urandom_range(0, 3));
    endfunction

    task automatic apply(input logic ir, input logic [31:0] ia, input logic dr,
                         input logic [31:0] da, input logic [31:0] dw, input logic [3:0] we);
        i_req = ir; i_addr = ia; d_req = dr; d_addr = da; d_wdata = dw; d_wea = we;
        #2;
    endtask

    // Advance one clock: update reference model from the rules, then service the BRAM.
    task automatic tick();
        logic        gi, gd, men;
        logic [11:0] ma;
        logic [3:0]  mw;
        logic [31:0] md;
        int          w;
        gi = pred_i();
        gd = d_req && !gi;
        men = mem_en; ma = mem_addr; mw = mem_wea; md = mem_wdata;
        exp_owner = 0; exp_err = 1'b0; exp_data = '0;
        if (gi) begin
            exp_owner = 1;
            exp_err = !in_win(i_addr);
            if (!exp_err) exp_data = ref_mem[widx(i_addr)];
        end else if (gd && d_wea == 4'b0000) begin
            exp_owner = 2;
            exp_err = !in_win(d_addr);
            if (!exp_err) exp_data = ref_mem[widx(d_addr)];
        end else if (gd && in_win(d_addr)) begin
            w = widx(d_addr);
            for (int b = 0; b < 4; b++)
                if (d_wea[b]) ref_mem[w][8*b +: 8] = d_wdata[8*b +: 8];
        end
        if (!i_req || gi) losses = 0;
        else if (losses < STARVE_MAX) losses = losses + 1;
        @(posedge clk);
        if (men) begin
            mem_rdata = bram[ma];
            for (int b = 0; b < 4; b++)
                if (mw[b]) bram[ma][8*b +: 8] = md[8*b +: 8];
        end
        #1;
    endtask

    task automatic test_reset();
        #3;
        n_checks++; if (i_gnt !== 1'b0 || d_gnt !== 1'b0) begin n_fail++; $display("FAIL reset_gnt: got %b%b expected 00", i_gnt, d_gnt); end
        n_checks++; if (i_rvalid !== 1'b0 || d_rvalid !== 1'b0) begin n_fail++; $display("FAIL reset_rvalid: got %b%b expected 00", i_rvalid, d_rvalid); end
        n_checks++; if (mem_en !== 1'b0 || stall_fetch !== 1'b0 || d_err !== 1'b0 || i_err !== 1'b0) begin n_fail++; $display("FAIL reset_misc: en=%b stall=%b derr=%b ierr=%b expected 0", mem_en, stall_fetch, d_err, i_err); end
        reset_n = 1'b1;
        losses = 0; exp_owner = 0;
        @(posedge clk); #1;
    endtask

    task automatic test_fetch_single();
        apply(1'b1, 32'h4000_0010, 1'b0, '0, '0, 4'b0000);
        n_checks++; if (i_gnt !== 1'b1 || d_gnt !== 1'b0) begin n_fail++; $display("FAIL fetch_gnt: got i=%b d=%b expected i=1 d=0", i_gnt, d_gnt); end
        n_checks++; if (mem_en !== 1'b1 || mem_addr !== 12'd4 || mem_wea !== 4'b0000) begin n_fail++; $display("FAIL fetch_mem: got en=%b addr=%0d wea=%b expected 1/4/0000", mem_en, mem_addr, mem_wea); end
        tick();
        apply(1'b0, '0, 1'b0, '0, '0, 4'b0000);
        n_checks++; if (i_rvalid !== 1'b1 || i_rdata !== ref_mem[4] || i_err !== 1'b0) begin n_fail++; $display("FAIL fetch_resp: got v=%b data=%h err=%b expected 1/%h/0", i_rvalid, i_rdata, i_err, ref_mem[4]); end
        n_checks++; if (d_rvalid !== 1'b0 || d_rdata !== 32'h0) begin n_fail++; $display("FAIL fetch_nonowner: got d_rvalid=%b d_rdata=%h expected 0/0", d_rvalid, d_rdata); end
        tick();
    endtask

    task automatic test_store_load();
        logic [31:0] expw;
        expw = {ref_mem[8][31:16], 16'h1234};
        apply(1'b0, '0, 1'b1, 32'h4000_0020, 32'hA5A5_1234, 4'b0011);
        n_checks++; if (d_gnt !== 1'b1 || mem_en !== 1'b1 || mem_addr !== 12'd8 || mem_wea !== 4'b0011 || d_err !== 1'b0) begin n_fail++; $display("FAIL store_mem: got gnt=%b en=%b addr=%0d wea=%b err=%b expected 1/1/8/0011/0", d_gnt, mem_en, mem_addr, mem_wea, d_err); end
        tick();
        apply(1'b0, '0, 1'b1, 32'h4000_0020, '0, 4'b0000);
        n_checks++; if (d_rvalid !== 1'b0) begin n_fail++; $display("FAIL store_norvalid: got %b expected 0", d_rvalid); end
        tick();
        apply(1'b0, '0, 1'b0, '0, '0, 4'b0000);
        n_checks++; if (d_rvalid !== 1'b1 || d_rdata[15:0] !== 16'h1234 || d_rdata !== expw) begin n_fail++; $display("FAIL raw_load: got v=%b data=%h expected 1/%h", d_rvalid, d_rdata, expw); end
        tick();
    endtask

    task automatic test_starvation();
        logic ei;
        apply(1'b1, 32'h4000_0100, 1'b1, 32'h4000_0200, '0, 4'b0000);
        for (int k = 0; k < 12; k++) begin
            ei = (k % 4) == 3;
            n_checks++; if (i_gnt !== ei || d_gnt !== !ei || stall_fetch !== !ei) begin n_fail++; $display("FAIL starve_pattern[%0d]: got i=%b d=%b stall=%b expected i=%b", k, i_gnt, d_gnt, stall_fetch, ei); end
            tick();
            #2;
            n_checks++; if (i_rvalid !== ei || d_rvalid !== !ei) begin n_fail++; $display("FAIL starve_owner[%0d]: got i=%b d=%b expected i=%b", k, i_rvalid, d_rvalid, ei); end
        end
        apply(1'b0, '0, 1'b0, '0, '0, 4'b0000);
        tick();
    endtask

    task automatic test_out_of_window();
        logic [31:0] addrs [3];
        logic        errs [3];
        logic [31:0] expd;
        addrs[0] = 32'h3FFF_FFFC; addrs[1] = 32'h4000_4000; addrs[2] = 32'h4000_3FFC;
        errs[0] = 1'b1; errs[1] = 1'b1; errs[2] = 1'b0;
        for (int k = 0; k < 3; k++) begin
            expd = errs[k] ? 32'h0 : ref_mem[DEPTH-1];
            apply(1'b0, '0, 1'b1, addrs[k], '0, 4'b0000);
            n_checks++; if (d_gnt !== 1'b1 || mem_en !== !errs[k]) begin n_fail++; $display("FAIL oow_en[%0d]: got gnt=%b en=%b expected 1/%b", k, d_gnt, mem_en, !errs[k]); end
            tick();
            apply(1'b0, '0, 1'b0, '0, '0, 4'b0000);
            n_checks++; if (d_rvalid !== 1'b1 || d_err !== errs[k] || d_rdata !== expd) begin n_fail++; $display("FAIL oow_resp[%0d]: got v=%b err=%b data=%h expected 1/%b/%h", k, d_rvalid, d_err, d_rdata, errs[k], expd); end
        end
        apply(1'b0, '0, 1'b1, 32'h4000_4000, 32'hFFFF_FFFF, 4'b1111);
        n_checks++; if (d_gnt !== 1'b1 || d_err !== 1'b1 || mem_en !== 1'b0 || mem_wea !== 4'b0000) begin n_fail++; $display("FAIL oow_write: got gnt=%b err=%b en=%b wea=%b expected 1/1/0/0000", d_gnt, d_err, mem_en, mem_wea); end
        tick();
        apply(1'b1, 32'h0000_0100, 1'b0, '0, '0, 4'b0000);
        n_checks++; if (d_rvalid !== 1'b0 || i_gnt !== 1'b1 || mem_en !== 1'b0) begin n_fail++; $display("FAIL oow_fetch_req: got drv=%b ignt=%b en=%b expected 0/1/0", d_rvalid, i_gnt, mem_en); end
        tick();
        apply(1'b0, '0, 1'b0, '0, '0, 4'b0000);
        n_checks++; if (i_rvalid !== 1'b1 || i_err !== 1'b1 || i_rdata !== 32'h0) begin n_fail++; $display("FAIL oow_fetch_resp: got v=%b err=%b data=%h expected 1/1/0", i_rvalid, i_err, i_rdata); end
        tick();
    endtask

    task automatic test_reset_midflight();
        logic ei;
        apply(1'b1, 32'h4000_0040, 1'b1, 32'h4000_0030, '0, 4'b0000);
        tick();
        tick();
        apply(1'b0, '0, 1'b0, '0, '0, 4'b0000);
        n_checks++; if (d_rvalid !== 1'b1) begin n_fail++; $display("FAIL midflight_pending: got d_rvalid=%b expected 1", d_rvalid); end
        #1 reset_n = 1'b0;
        #1;
        n_checks++; if (d_rvalid !== 1'b0 || i_rvalid !== 1'b0 || d_rdata !== 32'h0) begin n_fail++; $display("FAIL async_reset: got drv=%b irv=%b drd=%h expected 0/0/0", d_rvalid, i_rvalid, d_rdata); end
        losses = 0; exp_owner = 0;
        #2 reset_n = 1'b1;
        apply(1'b1, 32'h4000_0040, 1'b1, 32'h4000_0030, '0, 4'b0000);
        for (int k = 0; k < 4; k++) begin
            ei = k == 3;
            n_checks++; if (i_gnt !== ei || d_gnt !== !ei) begin n_fail++; $display("FAIL post_reset_arb[%0d]: got i=%b d=%b expected i=%b", k, i_gnt, d_gnt, ei); end
            tick();
            #2;
        end
        apply(1'b0, '0, 1'b0, '0, '0, 4'b0000);
        tick();
    endtask

    // mode 0: alternating single requesters; mode 1: contested, requests held until granted.
    task automatic test_random(input int mode, input int cycles);
        logic        pi, pd, gi, exp_men, exp_derr;
        logic [31:0] ia, da, dw, wa;
        logic [3:0]  dwe, exp_mwe;
        int          resp_seen, resp_exp;
        pi = 1'b0; pd = 1'b0; ia = '0; da = '0; dw = '0; dwe = '0;
        resp_seen = 0; resp_exp = 0;
        for (int k = 0; k <= cycles; k++) begin
            if (k == cycles) begin
                pi = 1'b0; pd = 1'b0;
            end else if (mode == 0) begin
                pi = (k % 2) == 0; pd = !pi;
                if (pi) ia = rand_addr();
                else begin
                    da = rand_addr(); dw = $urandom;
                    dwe = ($urandom_range(0, 1) == 1) ? 4'($urandom_range(1, 15)) : 4'b0000;
                end
            end else begin
                if (!pi && $urandom_range(0, 3) != 0) begin pi = 1'b1; ia = rand_addr(); end
                if (!pd && $urandom_range(0, 3) != 0) begin
                    pd = 1'b1; da = rand_addr(); dw = $urandom;
                    dwe = ($urandom_range(0, 1) == 1) ? 4'($urandom_range(1, 15)) : 4'b0000;
                end
            end
            apply(pi, ia, pd, da, dw, dwe);
            gi = pred_i();
            wa = gi ? ia : da;
            exp_men = (pi || pd) && in_win(wa);
            exp_mwe = (!gi && pd && in_win(da)) ? dwe : 4'b0000;
            exp_derr = (exp_owner == 2 && exp_err) || (pd && !gi && dwe != 4'b0000 && !in_win(da));
            n_checks++; if (i_gnt !== gi || d_gnt !== (pd && !gi) || stall_fetch !== (pi && !gi)) begin n_fail++; $display("FAIL rnd%0d_arb[%0d]: got i=%b d=%b stall=%b expected i=%b d=%b", mode, k, i_gnt, d_gnt, stall_fetch, gi, pd && !gi); end
            n_checks++; if (mem_en !== exp_men || mem_wea !== exp_mwe || (exp_men && mem_addr !== 12'(widx(wa)))) begin n_fail++; $display("FAIL rnd%0d_mem[%0d]: got en=%b wea=%b addr=%h expected en=%b wea=%b addr=%h", mode, k, mem_en, mem_wea, mem_addr, exp_men, exp_mwe, 12'(widx(wa))); end
            n_checks++; if (i_rvalid !== (exp_owner == 1) || i_rdata !== ((exp_owner == 1) ? exp_data : 32'h0) || i_err !== (exp_owner == 1 && exp_err)) begin n_fail++; $display("FAIL rnd%0d_iresp[%0d]: got v=%b data=%h err=%b expected v=%b data=%h", mode, k, i_rvalid, i_rdata, i_err, exp_owner == 1, exp_data); end
            n_checks++; if (d_rvalid !== (exp_owner == 2) || d_rdata !== ((exp_owner == 2) ? exp_data : 32'h0) || d_err !== exp_derr) begin n_fail++; $display("FAIL rnd%0d_dresp[%0d]: got v=%b data=%h err=%b expected v=%b data=%h err=%b", mode, k, d_rvalid, d_rdata, d_err, exp_owner == 2, exp_data, exp_derr); end
            resp_seen += int'(i_rvalid) + int'(d_rvalid);
            if (k == cycles) break;
            tick();
            if (exp_owner != 0) resp_exp++;
            if (gi) pi = 1'b0;
            else if (pd) pd = 1'b0;
        end
        n_checks++; if (resp_seen !== resp_exp) begin n_fail++; $display("FAIL rnd%0d_resp_count: got %0d expected %0d", mode, resp_seen, resp_exp); end
        apply(1'b0, '0, 1'b0, '0, '0, 4'b0000);
        tick();
    endtask

    initial begin
        logic [31:0] v;
        for (int i = 0; i < DEPTH; i++) begin
            v = $urandom;
            bram[i] = v;
            ref_mem[i] = v;
        end
        losses = 0; exp_owner = 0; exp_data = '0; exp_err = 1'b0;
        test_reset();
        test_fetch_single();
        test_store_load();
        test_starvation();
        test_out_of_window();
        test_reset_midflight();
        test_random(0, 100);
        test_random(1, 150);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares one single-ported, 1-cycle-read-latency BRAM between the core's instruction-fetch port (PC side) and data port (mem_adr/mem_wdata/wea side).
- Issues per-requester grants and routes each read response back to its owner one cycle later.
- Drives a stall request into the hazard logic whenever fetch is denied.
- Prevents fetch starvation with a bounded priority counter, and flags out-of-window addresses.

Parameters:
- XLEN, 32, data/address width.
- BASE_ADDR, 32'h4000_0000, byte address mapped to BRAM word 0.
- MEM_AW, 12, BRAM word-address width; window is BASE_ADDR .. BASE_ADDR + 4*2^MEM_AW - 1.
- STARVE_MAX, 3, consecutive contested cycles fetch may lose before it is forced to win; range 0..15.

Ports:
- clk  in  1  clock, all state on rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- i_req  in  1  fetch request.
- i_addr  in  XLEN  fetch byte address.
- i_gnt  out  1  fetch accepted this cycle.
- i_rvalid  out  1  fetch data valid (one cycle after i_gnt).
- i_rdata  out  XLEN  fetch data.
- i_err  out  1  with i_rvalid: granted address was out of window.
- d_req  in  1  data request.
- d_addr  in  XLEN  data byte address.
- d_wdata  in  XLEN  store data, already lane-aligned.
- d_wea  in  4  byte write enables; 0 means read.
- d_gnt  out  1  data accepted this cycle.
- d_rvalid  out  1  load data valid (reads only).
- d_rdata  out  XLEN  load data.
- d_err  out  1  with d_rvalid, or with d_gnt for a write: out of window.
- stall_fetch  out  1  i_req && !i_gnt.
- mem_en  out  1  BRAM enable.
- mem_addr  out  MEM_AW  BRAM word address.
- mem_wdata  out  XLEN  BRAM write data.
- mem_wea  out  4  BRAM byte write enables.
- mem_rdata  in  XLEN  BRAM read data, valid the cycle after mem_en with mem_wea==0.

Behaviour:
- Reset (reset_n low, asynchronous): starve_cnt=0, resp_owner=NONE, resp_err=0. All registered outputs are 0 immediately. Combinational outputs see the reset state; an in-flight response is dropped.
- Arbitration is combinational in the request cycle:
  - Single requester wins.
  - Both requesting: data wins unless starve_cnt == STARVE_MAX, in which case fetch wins.
  - Exactly one of i_gnt/d_gnt is high when any request is present.
- starve_cnt:
  - +1 when i_req && d_gnt.
  - Cleared on i_gnt, or when i_req is low.
  - Saturates at STARVE_MAX.
- In-window check on the winner's address:
  - offset = addr - BASE_ADDR, unsigned.
  - in-window iff offset < 4*2^MEM_AW.
  - addr[1:0] is ignored.
- In-window winner: mem_en=1, mem_addr=offset[MEM_AW+1:2]. For a data winner, mem_wea=d_wea and mem_wdata=d_wdata. For a fetch winner, mem_wea=0.
- Out-of-window winner: mem_en=0 and mem_wea=0. The request is still granted.
  - Read: the response is rdata=0 with err=1.
  - Write: d_err pulses with d_gnt and the write is dropped.
- resp_owner register, set at the edge after a grant:
  - IFETCH if the fetch was granted.
  - DATA if a data read was granted.
  - NONE if idle or a data write.
  - resp_err is latched alongside.
- Response cycle:
  - resp_owner==IFETCH: i_rvalid=1, i_rdata = resp_err ? 0 : mem_rdata, i_err=resp_err.
  - resp_owner==DATA: same signals on the d_ side.
  - Non-owner rdata = 0.
- Latency: exactly 1 cycle grant-to-rvalid. Back-to-back grants every cycle are allowed with full throughput.
- A write followed by a read to the same word on the next cycle returns the new data; the BRAM is read-first per port and the write has committed.
- Requesters must hold req/addr/wdata stable until gnt. The arbiter does not buffer denied requests.
- stall_fetch is purely combinational.

Decomposition:
- Shared defines: XLEN, the response-owner encodings (RESP_NONE=2'd0, RESP_IFETCH=2'd1, RESP_DATA=2'd2), and the default BASE_ADDR reset-PC constant.
- One natural sub-module: addr_window_check (combinational offset and in-window compute), instantiated once on the muxed winner address.
- Arbitration, starvation counter and response routing stay in the top.

Test Plan:
- Idle, then i_req=1, i_addr=32'h4000_0010 alone -> i_gnt=1, mem_addr=4, mem_wea=0; next cycle i_rvalid=1, i_rdata=mem_rdata, d_rvalid=0.
- d_req store d_addr=32'h4000_0020, d_wea=4'b0011, d_wdata=32'hA5A5_1234 -> mem_wea=4'b0011, mem_addr=8, d_rvalid never asserted; load of the same word next cycle returns 16'h1234 in the low half.
- Both requesting continuously, STARVE_MAX=3 -> grant pattern D,D,D,I repeating; stall_fetch high on the D cycles; starve_cnt returns to 0 after the I grant.
- d_req read d_addr=32'h3FFF_FFFC, then d_addr=32'h4000_4000 -> mem_en=0 both; d_rvalid=1, d_rdata=0, d_err=1 each following cycle. 32'h4000_3FFC is in-window.
- Pull reset_n low mid-cycle with resp_owner=DATA pending -> d_rvalid and i_rvalid drop to 0 asynchronously; after release, first grant behaves as from idle.
- Alternate i/d single requests every cycle for 100 cycles against a BRAM model -> every response arrives exactly 1 cycle after its grant at the correct owner, and no response is lost or duplicated.
